// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================
// Module : div_pkg
// Shared ALU codes, iteration count and FSM state encoding for the divider.
// Rev    : 1.0
// ============================================================
package div_pkg;

  localparam int ITER = 32;
  localparam int FN_W = 6;

  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_ADDU = 6'b011001;
  localparam logic [5:0] FN_SUBU = 6'b011011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SUB   = 3'd2,
    S_SHIFT = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5,
    S_DZ    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter_counter.sv
`default_nettype none
// ============================================================
// Module : div_iter_counter
// Saturating iteration counter 0..ITER; done flags the final count.
// Rev    : 1.0
// ============================================================
module div_iter_counter import div_pkg::*; #(
  parameter int ITER = div_pkg::ITER
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(ITER + 1);

  logic [CW-1:0] r_count;

  assign done = (r_count == CW'(ITER));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (inc && !done) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_control.sv
`default_nettype none
// ============================================================
// Module : div_control
// Restoring-divider sequencer (INIT, 32 x SUB/SHIFT, FIX, DONE).
// Optional divide-by-zero trap when DIV_ZERO_CHECK_EN is defined.
// Rev    : 1.0
// ============================================================
module div_control import div_pkg::*; #(
  parameter int ITER = div_pkg::ITER,
  parameter int FN_W = div_pkg::FN_W
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Run,
  input  logic            Rem_sign,
  input  logic            Div_zero,
  output logic            W_ctrl,
  output logic [FN_W-1:0] ALU_ctrl,
  output logic            HI_W,
  output logic            SLL_ctrl,
  output logic            Q_bit,
  output logic            SRH_ctrl,
  output logic            Ready,
  output logic            Dz_err
);

  state_t r_state;
  logic   r_neg;
  logic   w_cnt_clr;
  logic   w_cnt_inc;
  logic   w_cnt_done;
  logic   w_keep;

  // The counter advances on the SUB->SHIFT edge, so SHIFT already sees the updated count.
  assign w_cnt_clr = Reset || (r_state == S_IDLE);
  assign w_cnt_inc = (r_state == S_SUB);

  div_iter_counter #(
    .ITER (ITER)
  ) u_iter_counter (
    .clk  (clk),
    .clr  (w_cnt_clr),
    .inc  (w_cnt_inc),
    .done (w_cnt_done)
  );

  assign w_keep   = (r_state == S_SHIFT) && !r_neg;
  assign HI_W     = w_keep;
  assign Q_bit    = w_keep;

`ifndef DIV_ZERO_CHECK_EN
  logic w_unused_div_zero;
  assign w_unused_div_zero = Div_zero;
  assign Dz_err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_neg    <= 1'b0;
      W_ctrl   <= 1'b1;
      ALU_ctrl <= FN_W'(FN_NOP);
      SLL_ctrl <= 1'b0;
      SRH_ctrl <= 1'b0;
      Ready    <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      Dz_err   <= 1'b0;
`endif
    end else begin
      W_ctrl   <= 1'b0;
      ALU_ctrl <= FN_W'(FN_NOP);
      SLL_ctrl <= 1'b0;
      SRH_ctrl <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Run) begin
`ifdef DIV_ZERO_CHECK_EN
            if (Div_zero) begin
              r_state <= S_DZ;
            end else begin
              r_state  <= S_INIT;
              SLL_ctrl <= 1'b1;
            end
`else
            r_state  <= S_INIT;
            SLL_ctrl <= 1'b1;
`endif
          end
        end
        S_INIT: begin
          r_state  <= S_SUB;
          ALU_ctrl <= FN_W'(FN_SUBU);
        end
        S_SUB: begin
          r_state  <= S_SHIFT;
          r_neg    <= Rem_sign;
          ALU_ctrl <= FN_W'(FN_SUBU);
          SLL_ctrl <= 1'b1;
        end
        S_SHIFT: begin
          if (w_cnt_done) begin
            r_state  <= S_FIX;
            SRH_ctrl <= 1'b1;
          end else begin
            r_state  <= S_SUB;
            ALU_ctrl <= FN_W'(FN_SUBU);
          end
        end
        S_FIX: begin
          r_state <= S_DONE;
          Ready   <= 1'b1;
        end
        S_DONE: begin
          Ready <= 1'b1;
        end
`ifdef DIV_ZERO_CHECK_EN
        // Flags appear one cycle after entering DZ.
        S_DZ: begin
          Ready  <= 1'b1;
          Dz_err <= 1'b1;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_control.sv
`default_nettype none
// ============================================================
// Module : tb_div_control
// Self-checking bench: datapath model plus schedule/arithmetic reference.
// Rev    : 1.0
// ============================================================
module tb_div_control;
  import div_pkg::*;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DZ   = 2;

  logic            clk;
  logic            Reset;
  logic            Run;
  logic            Rem_sign;
  logic            Div_zero;
  logic            W_ctrl;
  logic [FN_W-1:0] ALU_ctrl;
  logic            HI_W;
  logic            SLL_ctrl;
  logic            Q_bit;
  logic            SRH_ctrl;
  logic            Ready;
  logic            Dz_err;

  logic [31:0] dividend;
  logic [31:0] divisor;

  int total = 0;
  int bad   = 0;

  div_control dut (
    .clk      (clk),
    .Reset    (Reset),
    .Run      (Run),
    .Rem_sign (Rem_sign),
    .Div_zero (Div_zero),
    .W_ctrl   (W_ctrl),
    .ALU_ctrl (ALU_ctrl),
    .HI_W     (HI_W),
    .SLL_ctrl (SLL_ctrl),
    .Q_bit    (Q_bit),
    .SRH_ctrl (SRH_ctrl),
    .Ready    (Ready),
    .Dz_err   (Dz_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath model; HI carries one guard bit so large divisors cannot overflow.
  logic [32:0] dp_hi;
  logic [31:0] dp_lo;
  logic [31:0] dp_div;
  logic [32:0] dp_h;

  assign Div_zero = (divisor == 32'd0);
  assign Rem_sign = (dp_hi < {1'b0, dp_div});
  assign dp_h     = HI_W ? (dp_hi - {1'b0, dp_div}) : dp_hi;

  always @(posedge clk) begin
    if (W_ctrl) begin
      dp_hi  <= '0;
      dp_lo  <= dividend;
      dp_div <= divisor;
    end else if (SLL_ctrl) begin
      dp_hi <= {dp_h[31:0], dp_lo[31]};
      dp_lo <= {dp_lo[30:0], Q_bit};
    end else if (SRH_ctrl) begin
      dp_hi <= dp_h >> 1;
    end else begin
      dp_hi <= dp_h;
    end
  end

  int n_sll, n_srh, n_hiw, n_q;
  always @(negedge clk) begin
    if (SLL_ctrl) n_sll++;
    if (SRH_ctrl) n_srh++;
    if (HI_W) n_hiw++;
    if (SLL_ctrl && Q_bit) n_q++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: phase and cycle offset since the Run-sampling edge, quotient from plain division.
  bit          m_started = 1'b0;
  bit          m_rst;
  int          m_ph;
  int          m_t;
  logic [31:0] m_q;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (Reset) begin
      m_rst = 1'b1;
      m_ph  = PH_IDLE;
      m_t   = 0;
    end else begin
      m_rst = 1'b0;
      if (m_ph == PH_IDLE) begin
        if (Run) begin
          m_t = 1;
          if (DZ_EN && divisor == 32'd0) begin
            m_ph = PH_DZ;
          end else begin
            m_ph = PH_RUN;
            m_q  = (divisor == 32'd0) ? 32'hFFFF_FFFF : dividend / divisor;
          end
        end
      end else if (m_t < 1000) begin
        m_t++;
      end
    end
  end

  logic            e_w, e_hiw, e_sll, e_q, e_srh, e_rdy, e_dz, qb;
  logic [FN_W-1:0] e_alu;
  always @(negedge clk) begin
    if (m_started) begin
      e_w = m_rst; e_alu = FN_NOP; e_hiw = 0; e_sll = 0; e_q = 0;
      e_srh = 0; e_rdy = 0; e_dz = 0;
      if (!m_rst && m_ph == PH_RUN) begin
        if (m_t == 1) begin
          e_sll = 1'b1;
        end else if (m_t <= 2 * ITER + 1) begin
          e_alu = FN_SUBU;
          if (m_t % 2 == 1) begin
            qb    = m_q[ITER - 1 - (m_t - 3) / 2];
            e_sll = 1'b1;
            e_hiw = qb;
            e_q   = qb;
          end
        end else if (m_t == 2 * ITER + 2) begin
          e_srh = 1'b1;
        end else begin
          e_rdy = 1'b1;
        end
      end else if (!m_rst && m_ph == PH_DZ && m_t >= 2) begin
        e_rdy = 1'b1;
        e_dz  = 1'b1;
      end
      chk("outputs", {W_ctrl, ALU_ctrl, HI_W, SLL_ctrl, Q_bit, SRH_ctrl, Ready, Dz_err},
                     {e_w, e_alu, e_hiw, e_sll, e_q, e_srh, e_rdy, e_dz});
    end
  end

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Reset = 1'b1; Run = 1'b0; dividend = a; divisor = b;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
  endtask

  // Returns the cycle (relative to the Run-sampling edge) in which Ready was first seen.
  task automatic start_and_wait(input int abort_at, output int cyc);
    Run = 1'b1;
    n_sll = 0; n_srh = 0; n_hiw = 0; n_q = 0;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == abort_at) begin
        Reset = 1'b1;
        Run   = 1'b0;
        break;
      end
      if (Ready) break;
      Run = 1'($urandom_range(0, 1));
    end
    Run = 1'b0;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int cyc);
    load_ops(a, b);
    start_and_wait(0, cyc);
    @(negedge clk);
  endtask

  int          cyc;
  logic [31:0] ra, rb;

  initial begin
    Reset = 1'b1; Run = 1'b0; dividend = 32'd0; divisor = 32'd1;
    repeat (3) @(negedge clk);
    chk("reset_wctrl", W_ctrl, 1);
    chk("reset_others", {ALU_ctrl, HI_W, SLL_ctrl, Q_bit, SRH_ctrl, Ready, Dz_err}, 0);
    Reset = 1'b0;
    @(negedge clk);
    chk("idle_wctrl", W_ctrl, 0);
    repeat (3) @(negedge clk);
    chk("idle_stays", {W_ctrl, SLL_ctrl, Ready}, 0);

    do_div(32'd7, 32'd2, cyc);
    chk("7div2_latency", cyc, 67);
    chk("7div2_lo", dp_lo, 3);
    chk("7div2_hi", dp_hi, 1);
    chk("7div2_sll_pulses", n_sll, 33);
    chk("7div2_srh_pulses", n_srh, 1);

    do_div(32'hFFFF_FFFF, 32'd1, cyc);
    chk("max_div1_lo", dp_lo, 32'hFFFF_FFFF);
    chk("max_div1_hi", dp_hi, 0);
    chk("max_div1_qbits", n_q, 32);

    do_div(32'd5, 32'd9, cyc);
    chk("5div9_lo", dp_lo, 0);
    chk("5div9_hi", dp_hi, 5);
    chk("5div9_hiw_pulses", n_hiw, 0);

    load_ops(32'd100, 32'd7);
    start_and_wait(30, cyc);
    @(negedge clk);
    chk("abort_wctrl", W_ctrl, 1);
    chk("abort_others", {ALU_ctrl, HI_W, SLL_ctrl, Q_bit, SRH_ctrl, Ready, Dz_err}, 0);
    do_div(32'd1000, 32'd3, cyc);
    chk("rerun_latency", cyc, 67);
    chk("rerun_lo", dp_lo, 333);
    chk("rerun_hi", dp_hi, 1);

    do_div(32'd10, 32'd0, cyc);
`ifdef DIV_ZERO_CHECK_EN
    chk("dz_latency", cyc, 2);
    chk("dz_flag", Dz_err, 1);
    chk("dz_no_strobes", n_sll + n_srh + n_hiw, 0);
`else
    chk("div0_latency", cyc, 67);
    chk("div0_lo", dp_lo, 32'hFFFF_FFFF);
    chk("div0_hi", dp_hi, 10);
`endif

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      case (i % 3)
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (rb == 32'd0) rb = 32'd1;
      do_div(ra, rb, cyc);
      chk("rand_latency", cyc, 67);
      chk("rand_lo", dp_lo, ra / rb);
      chk("rand_hi", dp_hi, {1'b0, ra % rb});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_control.md
# div_control

Sequencing control unit for the 32-bit unsigned restoring divider, the counterpart of the shift-add multiplier control in the same datapath family. It drives a 64-bit remainder register (HI|LO) and the shared ALU through 32 subtract/shift iterations. It produces the quotient bit by bit into LO and leaves the remainder in HI. It handshakes with the top level through Run/Ready and owns no datapath storage besides its state and iteration counter.

## Interface
- ITER, 32, number of divide iterations (operand width).
- FN_W, 6, ALU function code width.

- clk  in  1  clock.
- Reset  in  1  synchronous, active-high; also the operand-load strobe.
- Run  in  1  start/continue request, level-sensitive.
- Rem_sign  in  1  sign bit of the current ALU result (HI − divisor), combinational from the datapath.
- Div_zero  in  1  divisor == 0 (used only with DIV_ZERO_CHECK_EN).
- W_ctrl  out  1  load dividend/divisor into datapath registers.
- ALU_ctrl  out  FN_W  ALU function: FN_NOP or FN_SUBU.
- HI_W  out  1  write ALU result into HI this cycle.
- SLL_ctrl  out  1  shift HI|LO left by one, inserting Q_bit at LO[0].
- Q_bit  out  1  quotient bit shifted in.
- SRH_ctrl  out  1  shift HI right by one (final correction).
- Ready  out  1  result valid; held until Reset.
- Dz_err  out  1  divide-by-zero flag (configured builds only, else tied 0).

## Operation
- States: IDLE, INIT, SUB, SHIFT, FIX, DONE (+ DZ when configured).
- Reset: state=IDLE, counter=0, W_ctrl=1, ALU_ctrl=FN_NOP, HI_W=0, SLL_ctrl=0, Q_bit=0, SRH_ctrl=0, Ready=0, Dz_err=0.
- IDLE: W_ctrl=0. If Run=1, go to INIT; otherwise stay.
- INIT: SLL_ctrl=1, Q_bit=0 (pre-shift of the dividend) → SUB.
- SUB: ALU_ctrl=FN_SUBU, HI_W=0. Sample Rem_sign into the internal register neg → SHIFT.
- SHIFT: ALU_ctrl=FN_SUBU, HI_W=~neg, SLL_ctrl=1, Q_bit=~neg, counter+1. If counter reaches ITER, go to FIX; otherwise go to SUB.
- FIX: SRH_ctrl=1 → DONE.
- DONE: Ready=1. All strobes 0. Run is ignored. Leave only by Reset.
- Strobes (HI_W, SLL_ctrl, SRH_ctrl) are single-cycle pulses. ALU_ctrl returns to FN_NOP outside SUB/SHIFT.
- Counter: 6 bits, 0..ITER, no wrap. Reaching ITER is the only exit from the loop.
- Run dropping mid-operation does not pause; the sequence completes.
- Reset mid-operation aborts immediately to IDLE with the reset values above (datapath reloads via W_ctrl=1).

## Timing
- Outputs are Moore, decoded from registered state plus the neg register.
- Run sampled high in IDLE at edge k: INIT active in cycle k+1.
- SUB/SHIFT pairs occupy cycles k+2 … k+65, FIX is cycle k+66, and Ready rises after edge k+67.
- Total latency: 67 cycles from Run sample to Ready.
- Rem_sign must be valid at the edge ending each SUB cycle. HI held stable through SUB and SHIFT.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - In IDLE, Run=1 with Div_zero=1 goes to DZ instead of INIT.
  - DZ asserts Ready=1 and Dz_err=1 from the next cycle, with no datapath strobes, until Reset.
- Undefined:
  - Div_zero is ignored and Dz_err is tied 0.
  - Division by zero runs the full 67-cycle sequence, yielding LO=0xFFFFFFFF and HI=dividend.

## Structure
- Package div_pkg holds:
  - FN_NOP=6'b000000, FN_ADDU=6'b011001, FN_SUBU=6'b011011 (shared ALU encoding);
  - the state enum;
  - ITER.
- Sub-module div_iter_counter holds the 6-bit iteration counter:
  - inputs clr and inc;
  - output done (count==ITER).

## Test plan
- Reset asserted 3 cycles → W_ctrl=1, all other outputs 0. Release with Run=0 → W_ctrl=0, remains IDLE.
- Bench datapath model, 7÷2 → Ready at cycle k+67, LO=3, HI=1. Exactly 33 SLL_ctrl pulses and 1 SRH_ctrl pulse.
- 0xFFFFFFFF÷1 → LO=0xFFFFFFFF, HI=0. Q_bit=1 on all 32 SHIFT cycles.
- 5÷9 → LO=0, HI=5. HI_W never asserted.
- Reset at cycle k+30 → next cycle in IDLE with reset outputs. A new Run then completes in 67 cycles with the correct result.
- 10÷0 with DIV_ZERO_CHECK_EN → Ready=1 and Dz_err=1 at k+2, with no strobes. Without the macro → LO=0xFFFFFFFF, HI=10 at k+67.
